lower_memory_responder: RTL and testbench

- Responder end of the cache-to-lower-memory request interface; the L1 caches act as initiator.
- Accepts one level-held request at a time, waits a programmable latency, then pulses mem_ready with read data (or write completion).
- Backed by a word-addressed storage array; includes a side preload port for bench/boot image loading, and saturating transaction counters.
- Sits below L1 instruction/data caches as a simple main-memory model/controller.

---
 rtl/lower_memory_responder.sv | 160 ++++++++++++++++
 tb/tb_lower_memory_responder.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lower_memory_responder.sv
// Main-memory responder below the L1 caches: accepts one held request, waits a
// programmable latency, then pulses mem_ready with read data or write echo.
module lower_memory_responder #(
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int LATENCY         = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 mem_request,
  input  logic [31:0]          mem_address,
  input  logic                 mem_write_enable,
  input  logic [31:0]          mem_write_data,
  output logic [31:0]          mem_response_data,
  output logic                 mem_ready,
  output logic                 mem_error,
  output logic                 busy,
  input  logic                 preload_en,
  input  logic [31:0]          preload_addr,
  input  logic [31:0]          preload_data,
  output logic [CNT_WIDTH-1:0] read_count,
  output logic [CNT_WIDTH-1:0] write_count,
  output logic [CNT_WIDTH-1:0] error_count
);

  localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);
  localparam logic [7:0] LAT_INIT = 8'(LATENCY - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND, S_DRAIN} state_t;

  state_t state_q, state_d;
  logic [7:0]           lat_cnt_q, lat_cnt_d;
  logic [31:2]          addr_q, addr_d;
  logic                 we_q, we_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 ready_q, ready_d;
  logic                 error_q, error_d;
  logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_WIDTH-1:0] er_cnt_q, er_cnt_d;

  logic [31:0] mem_array [MEM_DEPTH_WORDS];

  logic             addr_in_range;
  logic [IDX_W-1:0] addr_idx;
  logic             preload_ok;
  logic [IDX_W-1:0] preload_idx;
  logic             commit_we;
  logic             unused_addr_lsbs;

  // Byte-lane bits are irrelevant for a word-wide store.
  assign unused_addr_lsbs = ^{mem_address[1:0], preload_addr[1:0]};

  assign addr_in_range = (addr_q[31:IDX_W+2] == '0);
  assign addr_idx      = addr_q[IDX_W+1:2];
  assign preload_ok    = preload_en && (preload_addr[31:IDX_W+2] == '0);
  assign preload_idx   = preload_addr[IDX_W+1:2];
  assign commit_we     = (state_q == S_RESPOND) && addr_in_range && we_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (mem_request) state_d = (LATENCY == 1) ? S_RESPOND : S_WAIT;
      S_WAIT:    if (lat_cnt_q == 8'd1) state_d = S_RESPOND;
      S_RESPOND: state_d = S_DRAIN;
      S_DRAIN:   if (!mem_request) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lat_cnt_d = lat_cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    error_d   = 1'b0;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    er_cnt_d  = er_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (mem_request) begin
          addr_d    = mem_address[31:2];
          we_d      = mem_write_enable;
          wdata_d   = mem_write_data;
          lat_cnt_d = LAT_INIT;
        end
      end
      S_WAIT: lat_cnt_d = lat_cnt_q - 8'd1;
      S_RESPOND: begin
        ready_d = 1'b1;
        if (!addr_in_range) begin
          rdata_d = '0;
          error_d = 1'b1;
          if (er_cnt_q != '1) er_cnt_d = er_cnt_q + CNT_ONE;
        end else if (we_q) begin
          rdata_d = wdata_q;
          if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_ONE;
        end else begin
          // Array read sees the pre-edge contents, so a colliding preload is not visible.
          rdata_d = mem_array[addr_idx];
          if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lat_cnt_q <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      er_cnt_q  <= '0;
    end else begin
      lat_cnt_q <= lat_cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      error_q   <= error_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      er_cnt_q  <= er_cnt_d;
    end
  end

  // Storage is not reset; a transaction write beats a preload to the same word.
  always_ff @(posedge clk) begin
    if (preload_ok && !(commit_we && (preload_idx == addr_idx)))
      mem_array[preload_idx] <= preload_data;
    if (commit_we)
      mem_array[addr_idx] <= wdata_q;
  end

  assign mem_response_data = rdata_q;
  assign mem_ready         = ready_q;
  assign mem_error         = error_q;
  assign busy              = (state_q != S_IDLE);
  assign read_count        = rd_cnt_q;
  assign write_count       = wr_cnt_q;
  assign error_count       = er_cnt_q;

endmodule

// File: tb/tb_lower_memory_responder.sv
// Bench for lower_memory_responder: directed and random transactions against a
// word-array reference model; a second instance covers LATENCY=1 saturation.
module tb_lower_memory_responder;
  localparam int LAT = 4;
  localparam int DEPTH = 1024;
  localparam int CW = 16;
  localparam int CW1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  logic        mem_request, mem_write_enable, mem_ready, mem_error, busy;
  logic [31:0] mem_address, mem_write_data, mem_response_data;
  logic        preload_en;
  logic [31:0] preload_addr, preload_data;
  logic [CW-1:0] read_count, write_count, error_count;

  logic        req1, we1, ready1, err1, busy1, pl_en1;
  logic [31:0] addr1, wdata1, rdata1, pl_addr1, pl_data1;
  logic [CW1-1:0] rc1, wc1, ec1;

  lower_memory_responder #(.MEM_DEPTH_WORDS(DEPTH), .LATENCY(LAT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .mem_request(mem_request), .mem_address(mem_address),
    .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
    .mem_response_data(mem_response_data), .mem_ready(mem_ready), .mem_error(mem_error),
    .busy(busy), .preload_en(preload_en), .preload_addr(preload_addr),
    .preload_data(preload_data), .read_count(read_count), .write_count(write_count),
    .error_count(error_count));

  lower_memory_responder #(.MEM_DEPTH_WORDS(DEPTH), .LATENCY(1), .CNT_WIDTH(CW1)) dut1 (
    .clk(clk), .rstn(rstn), .mem_request(req1), .mem_address(addr1),
    .mem_write_enable(we1), .mem_write_data(wdata1),
    .mem_response_data(rdata1), .mem_ready(ready1), .mem_error(err1),
    .busy(busy1), .preload_en(pl_en1), .preload_addr(pl_addr1),
    .preload_data(pl_data1), .read_count(rc1), .write_count(wc1),
    .error_count(ec1));

  int checks = 0;
  int errors = 0;

  // Reference model: word array plus plain transaction tallies.
  logic [31:0] mmem [DEPTH];
  bit          known [DEPTH];
  int n_rd = 0, n_wr = 0, n_er = 0;

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  task automatic model_txn(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input bit pl, input logic [31:0] pa, input logic [31:0] pd,
                           output logic [31:0] ed, output logic ee);
    bit inr;
    int idx, pidx;
    inr = (a < DEPTH * 4);
    idx = int'(a[11:2]);
    pidx = int'(pa[11:2]);
    ee = !inr;
    if (!inr) begin ed = '0; n_er++; end
    else if (w) begin ed = d; n_wr++; end
    else begin ed = mmem[idx]; n_rd++; end
    if (pl && pa < DEPTH * 4 && !(inr && w && pidx == idx)) begin
      mmem[pidx] = pd; known[pidx] = 1'b1;
    end
    if (inr && w) begin mmem[idx] = d; known[idx] = 1'b1; end
  endtask

  task automatic do_preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    preload_en = 1'b1; preload_addr = a; preload_data = d;
    @(posedge clk); #1;
    preload_en = 1'b0;
    if (a < DEPTH * 4) begin mmem[a[11:2]] = d; known[a[11:2]] = 1'b1; end
  endtask

  // Drives one transaction, scrambling inputs while busy, and records what was seen.
  task automatic do_txn(input logic [31:0] a, input logic w, input logic [31:0] d, input int hold,
                        input bit pl, input logic [31:0] pa, input logic [31:0] pd,
                        output int ready_at, output int pulses, output logic [31:0] data,
                        output logic err, output bit held_ok, output bit busy_ok,
                        output logic busy_after);
    data = '0; err = 1'b0;
    @(negedge clk);
    mem_request = 1'b1; mem_address = a; mem_write_enable = w; mem_write_data = d;
    @(posedge clk); #1;
    ready_at = -1; pulses = 0; held_ok = 1'b1; busy_ok = (busy === 1'b1);
    for (int k = 1; k <= LAT + hold; k++) begin
      @(negedge clk);
      mem_address = $urandom; mem_write_enable = 1'($urandom); mem_write_data = $urandom;
      if (pl && k == LAT) begin preload_en = 1'b1; preload_addr = pa; preload_data = pd; end
      @(posedge clk); #1;
      preload_en = 1'b0;
      if (mem_ready === 1'b1) begin
        pulses++;
        if (ready_at < 0) begin ready_at = k; data = mem_response_data; err = mem_error; end
      end else if (ready_at > 0 && mem_response_data !== data) held_ok = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    @(negedge clk);
    mem_request = 1'b0;
    @(posedge clk); #1;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    mem_request = 0; mem_address = 0; mem_write_enable = 0; mem_write_data = 0;
    preload_en = 0; preload_addr = 0; preload_data = 0;
    req1 = 0; addr1 = 0; we1 = 0; wdata1 = 0; pl_en1 = 0; pl_addr1 = 0; pl_data1 = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_ready, mem_error, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {mem_ready, mem_error, busy});
    end
    checks++;
    if (mem_response_data !== 32'h0) begin
      errors++; $display("FAIL reset_data got %h exp 0", mem_response_data);
    end
    checks++;
    if ({read_count, write_count, error_count} !== '0) begin
      errors++; $display("FAIL reset_counts got %0d/%0d/%0d exp 0", read_count, write_count, error_count);
    end
    checks++;
    if ({ready1, err1, busy1, rc1, wc1, ec1, rdata1} !== '0) begin
      errors++; $display("FAIL reset_dut1 got rdy%b cnt%0d data %h exp 0", ready1, rc1, rdata1);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_preload_read();
    logic [31:0] ed, data; logic ee, err, ba; int rat, pul; bit hok, bok;
    do_preload(32'h14, 32'hDEADBEEF);
    checks++;
    if (busy !== 1'b0 || read_count !== '0) begin
      errors++; $display("FAIL preload_side got busy %b rc %0d exp 0 0", busy, read_count);
    end
    model_txn(32'h14, 1'b0, 32'h0, 1'b0, 0, 0, ed, ee);
    do_txn(32'h14, 1'b0, 32'h0, 0, 1'b0, 0, 0, rat, pul, data, err, hok, bok, ba);
    checks++;
    if (rat !== LAT || pul !== 1) begin
      errors++; $display("FAIL read_latency got at %0d pulses %0d exp at %0d pulses 1", rat, pul, LAT);
    end
    checks++;
    if (data !== ed || err !== 1'b0) begin
      errors++; $display("FAIL read_data got %h err %b exp %h err 0", data, err, ed);
    end
    checks++;
    if (read_count !== CW'(n_rd)) begin
      errors++; $display("FAIL read_count got %0d exp %0d", read_count, n_rd);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] ed, data; logic ee, err, ba; int rat, pul; bit hok, bok;
    model_txn(32'h20, 1'b1, 32'h12345678, 1'b0, 0, 0, ed, ee);
    do_txn(32'h20, 1'b1, 32'h12345678, 0, 1'b0, 0, 0, rat, pul, data, err, hok, bok, ba);
    checks++;
    if (data !== ed || rat !== LAT) begin
      errors++; $display("FAIL write_echo got %h at %0d exp %h at %0d", data, rat, ed, LAT);
    end
    model_txn(32'h20, 1'b0, 32'h0, 1'b0, 0, 0, ed, ee);
    do_txn(32'h20, 1'b0, 32'h0, 0, 1'b0, 0, 0, rat, pul, data, err, hok, bok, ba);
    checks++;
    if (data !== ed) begin
      errors++; $display("FAIL write_readback got %h exp %h", data, ed);
    end
    checks++;
    if (write_count !== CW'(n_wr) || read_count !== CW'(n_rd)) begin
      errors++; $display("FAIL wr_counts got w%0d r%0d exp w%0d r%0d", write_count, read_count, n_wr, n_rd);
    end
  endtask

  task automatic test_hold();
    logic [31:0] ed, data; logic ee, err, ba; int rat, pul; bit hok, bok;
    model_txn(32'h14, 1'b0, 32'h0, 1'b0, 0, 0, ed, ee);
    do_txn(32'h14, 1'b0, 32'h0, 3, 1'b0, 0, 0, rat, pul, data, err, hok, bok, ba);
    checks++;
    if (pul !== 1 || rat !== LAT) begin
      errors++; $display("FAIL hold_pulses got %0d at %0d exp 1 at %0d", pul, rat, LAT);
    end
    checks++;
    if (bok !== 1'b1 || hok !== 1'b1 || data !== ed) begin
      errors++; $display("FAIL hold_busy_data got busy_ok %b held_ok %b data %h exp 1 1 %h", bok, hok, data, ed);
    end
    checks++;
    if (ba !== 1'b0) begin
      errors++; $display("FAIL hold_release got busy %b exp 0", ba);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] ed, data; logic ee, err, ba; int rat, pul; bit hok, bok;
    do_preload(32'h0, 32'h0BADF00D);
    model_txn(32'h1000, 1'b0, 32'h0, 1'b0, 0, 0, ed, ee);
    do_txn(32'h1000, 1'b0, 32'h0, 0, 1'b0, 0, 0, rat, pul, data, err, hok, bok, ba);
    checks++;
    if (data !== ed || err !== ee || rat !== LAT) begin
      errors++; $display("FAIL oor_read got %h err %b at %0d exp %h err %b at %0d", data, err, rat, ed, ee, LAT);
    end
    model_txn(32'h1000, 1'b1, 32'hFFFFFFFF, 1'b0, 0, 0, ed, ee);
    do_txn(32'h1000, 1'b1, 32'hFFFFFFFF, 0, 1'b0, 0, 0, rat, pul, data, err, hok, bok, ba);
    checks++;
    if (error_count !== CW'(n_er) || write_count !== CW'(n_wr) || err !== 1'b1) begin
      errors++; $display("FAIL oor_counts got e%0d w%0d err %b exp e%0d w%0d err 1", error_count, write_count, err, n_er, n_wr);
    end
    model_txn(32'h0, 1'b0, 32'h0, 1'b0, 0, 0, ed, ee);
    do_txn(32'h0, 1'b0, 32'h0, 0, 1'b0, 0, 0, rat, pul, data, err, hok, bok, ba);
    checks++;
    if (data !== ed) begin
      errors++; $display("FAIL oor_no_write got %h exp %h", data, ed);
    end
  endtask

  task automatic test_collision();
    logic [31:0] ed, data; logic ee, err, ba; int rat, pul; bit hok, bok;
    do_preload(32'h30, 32'h11110000);
    model_txn(32'h30, 1'b1, 32'hCAFE0001, 1'b1, 32'h30, 32'h22220000, ed, ee);
    do_txn(32'h30, 1'b1, 32'hCAFE0001, 0, 1'b1, 32'h30, 32'h22220000, rat, pul, data, err, hok, bok, ba);
    model_txn(32'h30, 1'b0, 32'h0, 1'b1, 32'h31, 32'h33330000, ed, ee);
    do_txn(32'h30, 1'b0, 32'h0, 0, 1'b1, 32'h31, 32'h33330000, rat, pul, data, err, hok, bok, ba);
    checks++;
    if (data !== ed) begin
      errors++; $display("FAIL coll_write_wins got %h exp %h", data, ed);
    end
    model_txn(32'h30, 1'b0, 32'h0, 1'b0, 0, 0, ed, ee);
    do_txn(32'h30, 1'b0, 32'h0, 0, 1'b0, 0, 0, rat, pul, data, err, hok, bok, ba);
    checks++;
    if (data !== ed) begin
      errors++; $display("FAIL coll_read_old got %h exp %h", data, ed);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] ed, data; logic ee, err, ba; int rat, pul; bit hok, bok;
    do_preload(32'h8, 32'hAAAA0000);
    @(negedge clk);
    mem_request = 1'b1; mem_address = 32'h8; mem_write_enable = 1'b1; mem_write_data = 32'h5555AAAA;
    @(posedge clk);
    @(posedge clk); #2;
    rstn = 1'b0;
    mem_request = 1'b0;
    #1;
    checks++;
    if ({mem_ready, mem_error, busy} !== 3'b000 || mem_response_data !== 32'h0
        || {read_count, write_count, error_count} !== '0) begin
      errors++; $display("FAIL abort_outputs got rdy %b busy %b data %h exp 0 0 0", mem_ready, busy, mem_response_data);
    end
    n_rd = 0; n_wr = 0; n_er = 0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (mem_ready !== 1'b0) begin
        errors++; $display("FAIL abort_no_ready got %b exp 0", mem_ready);
      end
    end
    @(negedge clk);
    rstn = 1'b1;
    model_txn(32'h8, 1'b0, 32'h0, 1'b0, 0, 0, ed, ee);
    do_txn(32'h8, 1'b0, 32'h0, 0, 1'b0, 0, 0, rat, pul, data, err, hok, bok, ba);
    checks++;
    if (data !== ed || read_count !== CW'(n_rd)) begin
      errors++; $display("FAIL abort_retained got %h rc %0d exp %h rc %0d", data, read_count, ed, n_rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, pa, pd, ed, data; logic w, ee, err, ba; int rat, pul, hold, wi; bit pl, hok, bok;
    for (int t = 0; t < 30; t++) begin
      wi = $urandom_range(0, 15);
      a = {20'h0, wi[9:0], 2'($urandom)};
      if ($urandom_range(0, 5) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
      w = 1'($urandom);
      if (!w && a < DEPTH * 4 && !known[a[11:2]]) w = 1'b1;
      d = $urandom;
      hold = $urandom_range(0, 2);
      pl = ($urandom_range(0, 2) == 0);
      pa = {20'h0, 6'h0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 4) == 0) pa = pa | 32'h0001_0000;
      pd = $urandom;
      model_txn(a, w, d, pl, pa, pd, ed, ee);
      do_txn(a, w, d, hold, pl, pa, pd, rat, pul, data, err, hok, bok, ba);
      checks++;
      if (rat !== LAT || pul !== 1 || data !== ed || err !== ee || hok !== 1'b1 || bok !== 1'b1 || ba !== 1'b0) begin
        errors++;
        $display("FAIL rand_txn%0d a %h we %b got at %0d n %0d data %h err %b exp at %0d n 1 data %h err %b",
                 t, a, w, rat, pul, data, err, LAT, ed, ee);
      end
      checks++;
      if (read_count !== CW'(sat(n_rd, CW)) || write_count !== CW'(sat(n_wr, CW)) || error_count !== CW'(sat(n_er, CW))) begin
        errors++;
        $display("FAIL rand_counts%0d got r%0d w%0d e%0d exp r%0d w%0d e%0d", t, read_count, write_count, error_count, n_rd, n_wr, n_er);
      end
    end
  endtask

  task automatic test_lat1_saturation();
    logic [31:0] words [5];
    for (int i = 0; i < 5; i++) begin
      words[i] = $urandom;
      @(negedge clk);
      pl_en1 = 1'b1; pl_addr1 = i * 4; pl_data1 = words[i];
      @(posedge clk); #1;
      pl_en1 = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req1 = 1'b1; addr1 = i * 4; we1 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (ready1 !== 1'b0) begin
        errors++; $display("FAIL lat1_early%0d got %b exp 0", i, ready1);
      end
      @(posedge clk); #1;
      checks++;
      if (ready1 !== 1'b1 || rdata1 !== words[i]) begin
        errors++; $display("FAIL lat1_resp%0d got rdy %b data %h exp 1 %h", i, ready1, rdata1, words[i]);
      end
      checks++;
      if (rc1 !== CW1'(sat(i + 1, CW1))) begin
        errors++; $display("FAIL lat1_count%0d got %0d exp %0d", i, rc1, sat(i + 1, CW1));
      end
      @(negedge clk);
      req1 = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mmem[i] = '0; known[i] = 1'b0; end
    test_reset();
    test_preload_read();
    test_write_read();
    test_hold();
    test_out_of_range();
    test_collision();
    test_reset_abort();
    test_random();
    test_lat1_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
